// File: rtl/traj_fetch_arbiter_if.sv
// Bus bundle between the processor/register side, dmem and the point buffer
// for the trajectory fetch arbiter.
interface traj_fetch_arbiter_if;
  logic [31:0] traj_enable;
  logic [31:0] traj_base;
  logic        proc_req;
  logic [11:0] proc_addr;
  logic [31:0] proc_data;
  logic        proc_wren;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_data;
  logic        dmem_wren;
  logic [31:0] dmem_q;
  logic        pt_wr_en;
  logic [7:0]  pt_wr_addr;
  logic [31:0] pt_wr_data;
  logic        busy;
  logic        done;

  modport slave (
    input  traj_enable, traj_base, proc_req, proc_addr, proc_data, proc_wren, dmem_q,
    output dmem_addr, dmem_data, dmem_wren, pt_wr_en, pt_wr_addr, pt_wr_data, busy, done
  );

  modport master (
    output traj_enable, traj_base, proc_req, proc_addr, proc_data, proc_wren, dmem_q,
    input  dmem_addr, dmem_data, dmem_wren, pt_wr_en, pt_wr_addr, pt_wr_data, busy, done
  );
endinterface

// File: rtl/traj_fetch_arbiter.sv
// Shares the dmem port between the processor and a trajectory burst-fetch engine
// that copies TRAJ_LEN words into the display point buffer using idle dmem cycles.
//
// state | meaning
// IDLE  | waiting for a rising edge on traj_enable[0]
// FETCH | issuing reads whenever the processor leaves dmem idle
// DRAIN | all reads issued, waiting for the remaining returns
// DONE  | one-cycle completion pulse; restarts if a start arrived meanwhile
module traj_fetch_arbiter #(
  parameter int TRAJ_LEN = 64,
  parameter int READ_LAT = 1
) (
  input logic              clock,
  input logic              reset,
  traj_fetch_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [8:0] LEN = 9'(TRAJ_LEN);

  state_t      state;
  logic [8:0]  issue_cnt;
  logic [8:0]  ret_cnt;
  logic [11:0] base;
  logic [11:0] base_next;
  logic        pending;
  logic        en_prev;
  logic        busy_r;
  logic        done_r;

  logic        tag_vld [READ_LAT];
  logic [7:0]  tag_idx [READ_LAT];

  logic        start;
  logic        issue;
  logic        head_vld;
  logic [7:0]  head_idx;
  logic [8:0]  issue_cnt_nxt;
  logic [8:0]  ret_cnt_nxt;
  logic        unused_bits;

  assign unused_bits   = ^{bus.traj_enable[31:1], bus.traj_base[31:12]};

  assign start         = bus.traj_enable[0] & ~en_prev;
  assign issue         = (state == FETCH) && !bus.proc_req && (issue_cnt < LEN);
  assign head_vld      = tag_vld[READ_LAT-1];
  assign head_idx      = tag_idx[READ_LAT-1];
  assign issue_cnt_nxt = issue_cnt + {8'd0, issue};
  assign ret_cnt_nxt   = ret_cnt + {8'd0, head_vld};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_prev <= 1'b0;
    end else begin
      en_prev <= bus.traj_enable[0];
    end
  end

  // Tag pipe tracks which dmem reads belong to the engine so processor reads
  // returning on dmem_q are never captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_idx[i] <= 8'd0;
      end
    end else begin
      tag_vld[0] <= issue;
      tag_idx[0] <= issue_cnt[7:0];
      for (int i = 1; i < READ_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      issue_cnt <= 9'd0;
      ret_cnt   <= 9'd0;
      base      <= 12'd0;
      base_next <= 12'd0;
      pending   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base      <= bus.traj_base[11:0];
            issue_cnt <= 9'd0;
            ret_cnt   <= 9'd0;
            busy_r    <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          issue_cnt <= issue_cnt_nxt;
          ret_cnt   <= ret_cnt_nxt;
          if (start) begin
            pending   <= 1'b1;
            base_next <= bus.traj_base[11:0];
          end
          if (issue_cnt_nxt == LEN) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          ret_cnt <= ret_cnt_nxt;
          if (start) begin
            pending   <= 1'b1;
            base_next <= bus.traj_base[11:0];
          end
          if (ret_cnt_nxt == LEN) begin
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          // A start seen in this very cycle is newer than any latched one.
          if (pending || start) begin
            base      <= start ? bus.traj_base[11:0] : base_next;
            pending   <= 1'b0;
            issue_cnt <= 9'd0;
            ret_cnt   <= 9'd0;
            state     <= FETCH;
          end else begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          pending <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.dmem_addr = bus.proc_addr;
    bus.dmem_data = bus.proc_data;
    bus.dmem_wren = 1'b0;
    if (bus.proc_req) begin
      bus.dmem_wren = bus.proc_wren;
    end else if ((state == FETCH) && (issue_cnt < LEN)) begin
      bus.dmem_addr = base + {3'd0, issue_cnt};
    end
  end

  assign bus.pt_wr_en   = head_vld;
  assign bus.pt_wr_addr = head_vld ? head_idx : 8'd0;
  assign bus.pt_wr_data = head_vld ? bus.dmem_q : 32'd0;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule
